// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DROP
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// imem request/response and decode hand-off signals of the fetch sequencer.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic                    imem_req;
  logic [XLEN_DEFAULT-1:0] imem_addr;
  logic                    imem_ack;
  logic [XLEN_DEFAULT-1:0] imem_rdata;
  logic                    instr_valid;
  logic [XLEN_DEFAULT-1:0] instr;
  logic [XLEN_DEFAULT-1:0] instr_pc;
  logic                    instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Next-PC selection: trap > aligned redirect > pending target > advance > hold.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN_DEFAULT
) (
  input  logic             trap_i,
  input  logic [WIDTH-1:0] trap_vector_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  input  logic             advance_i,
  input  logic             use_pending_i,
  input  logic [WIDTH-1:0] pending_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] next_pc_o,
  output logic             take_redirect_o,
  output logic             misalign_o
);

  logic aligned;
  assign aligned = (redirect_target_i[1:0] == 2'b00);

  always_comb begin
    // A misaligned redirect only reports when it would actually have been taken.
    misalign_o      = redirect_i & ~trap_i & ~aligned;
    take_redirect_o = trap_i | (redirect_i & aligned);
    if (trap_i)
      next_pc_o = trap_vector_i & ~WIDTH'(3);
    else if (redirect_i & aligned)
      next_pc_o = redirect_target_i;
    else if (use_pending_i)
      next_pc_o = pending_i;
    else if (advance_i)
      next_pc_o = pc_i + WIDTH'(INSTR_BYTES);
    else
      next_pc_o = pc_i;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sole owner of the PC, one-entry buffer towards decode.
//   state  | meaning
//   S_BOOT | one cycle after reset before the first request
//   S_REQ  | request outstanding at pc, waiting for imem_ack
//   S_HOLD | fetched instruction held for decode
//   S_DROP | stale request outstanding; redirect target parked in pend_q
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_sequencer_if.master   bus,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  input  logic                trap_valid,
  input  logic [XLEN-1:0]     trap_vector,
  output logic [XLEN-1:0]     pc,
  output logic                misalign_err
);

  fetch_state_e    state_q;
  logic            req_q, valid_q, misalign_q;
  logic [XLEN-1:0] pc_q, pend_q, instr_q, instr_pc_q;
  logic [XLEN-1:0] pc_d;
  logic            take, misalign, advance, use_pending;

  assign advance     = (state_q == S_HOLD) & bus.instr_ready;
  assign use_pending = (state_q == S_DROP);

  pc_next_sel #(.WIDTH(XLEN)) u_sel (
    .trap_i            (trap_valid),
    .trap_vector_i     (trap_vector),
    .redirect_i        (redirect_valid),
    .redirect_target_i (redirect_target),
    .advance_i         (advance),
    .use_pending_i     (use_pending),
    .pending_i         (pend_q),
    .pc_i              (pc_q),
    .next_pc_o         (pc_d),
    .take_redirect_o   (take),
    .misalign_o        (misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      pc_q       <= RESET_VECTOR;
      pend_q     <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= RESET_VECTOR;
    end else begin
      misalign_q <= misalign;
      case (state_q)
        S_BOOT: begin
          pc_q    <= pc_d;
          req_q   <= 1'b1;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (bus.imem_ack) begin
            if (take) begin
              pc_q <= pc_d;
            end else begin
              instr_q    <= bus.imem_rdata;
              instr_pc_q <= pc_q;
              valid_q    <= 1'b1;
              req_q      <= 1'b0;
              state_q    <= S_HOLD;
            end
          end else if (take) begin
            // Address must stay put until the ack, so park the target instead.
            pend_q  <= pc_d;
            state_q <= S_DROP;
          end
        end
        S_HOLD: begin
          if (take || bus.instr_ready) begin
            valid_q <= 1'b0;
            pc_q    <= pc_d;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          if (bus.imem_ack) begin
            pc_q    <= pc_d;
            state_q <= S_REQ;
          end else if (take) begin
            pend_q <= pc_d;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign pc              = pc_q;
  assign misalign_err    = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a wait-state-programmable imem responder.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid, trap_valid;
  logic [31:0] redirect_target, trap_vector;
  logic [31:0] pc;
  logic        misalign_err;

  int n_chk  = 0;
  int n_pass = 0;
  int wait_states = 0;
  int wcnt = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.master),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .pc              (pc),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return {a[31:16] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  // One cycle: clear pulses, then let imem answer after wait_states cycles of req.
  task automatic cycle();
    @(negedge clk);
    redirect_valid = 1'b0;
    trap_valid     = 1'b0;
    if (bus.imem_req) begin
      if (wcnt >= wait_states) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        wcnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.imem_ack = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"},      32'(bus.imem_req), 32'd0);
    check_eq({tag, "_addr"},     bus.imem_addr, 32'h0);
    check_eq({tag, "_pc"},       pc, 32'h0);
    check_eq({tag, "_valid"},    32'(bus.instr_valid), 32'd0);
    check_eq({tag, "_instr"},    bus.instr, 32'h0);
    check_eq({tag, "_instr_pc"}, bus.instr_pc, 32'h0);
    check_eq({tag, "_misalign"}, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0;     trap_vector = '0;
    bus.imem_ack = 1'b0;   bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    repeat (3) cycle();
    check_reset("rst");

    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    cycle();
    check_eq("boot_req", 32'(bus.imem_req), 32'd1);
    check_eq("boot_addr", bus.imem_addr, 32'h0);
    cycle();
    check_eq("f0_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("f0_pc", bus.instr_pc, 32'h0);
    check_eq("f0_instr", bus.instr, mem_word(32'h0));
    check_eq("f0_req_low", 32'(bus.imem_req), 32'd0);
    cycle();
    check_eq("f4_req", 32'(bus.imem_req), 32'd1);
    check_eq("f4_addr", bus.imem_addr, 32'h4);
    cycle();
    check_eq("f4_pc", bus.instr_pc, 32'h4);
    check_eq("f4_instr", bus.instr, 32'h0050_0093);

    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("bp_instr", bus.instr, 32'h0050_0093);
      check_eq("bp_pc", bus.instr_pc, 32'h4);
      check_eq("bp_req", 32'(bus.imem_req), 32'd0);
      check_eq("bp_valid", 32'(bus.instr_valid), 32'd1);
    end

    bus.instr_ready = 1'b1;
    wait_states = 3;
    cycle();
    check_eq("f8_req", 32'(bus.imem_req), 32'd1);
    check_eq("f8_addr", bus.imem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_target = 32'h100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("drop_addr", bus.imem_addr, 32'h8);
      check_eq("drop_req", 32'(bus.imem_req), 32'd1);
      check_eq("drop_valid", 32'(bus.instr_valid), 32'd0);
    end
    wait_states = 0;
    cycle();
    check_eq("r100_addr", bus.imem_addr, 32'h100);
    check_eq("r100_req", 32'(bus.imem_req), 32'd1);
    check_eq("r100_valid", 32'(bus.instr_valid), 32'd0);
    cycle();
    check_eq("r100_pc", bus.instr_pc, 32'h100);
    check_eq("r100_instr", bus.instr, mem_word(32'h100));

    trap_valid = 1'b1;     trap_vector = 32'h203;
    redirect_valid = 1'b1; redirect_target = 32'h100;
    cycle();
    check_eq("trap_kill", 32'(bus.instr_valid), 32'd0);
    check_eq("trap_addr", bus.imem_addr, 32'h200);
    check_eq("trap_req", 32'(bus.imem_req), 32'd1);
    cycle();
    check_eq("trap_pc", bus.instr_pc, 32'h200);

    bus.instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h102;
    cycle();
    check_eq("mis_pulse", 32'(misalign_err), 32'd1);
    check_eq("mis_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("mis_ipc", bus.instr_pc, 32'h200);
    check_eq("mis_pc", pc, 32'h200);
    bus.instr_ready = 1'b1;
    cycle();
    check_eq("mis_clear", 32'(misalign_err), 32'd0);
    check_eq("mis_next", bus.imem_addr, 32'h204);

    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    cycle();
    check_eq("ackredir_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check_eq("ackredir_valid", 32'(bus.instr_valid), 32'd0);
    cycle();
    check_eq("top_pc", bus.instr_pc, 32'hFFFF_FFFC);
    check_eq("top_instr", bus.instr, mem_word(32'hFFFF_FFFC));
    cycle();
    check_eq("wrap_addr", bus.imem_addr, 32'h0);
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_req", 32'(bus.imem_req), 32'd1);
    cycle();
    check_eq("wrap_ipc", bus.instr_pc, 32'h0);

    wait_states = 3;
    cycle();
    check_eq("pre_drop_addr", bus.imem_addr, 32'h4);
    redirect_valid = 1'b1; redirect_target = 32'h300;
    cycle();
    check_eq("drop2_addr", bus.imem_addr, 32'h4);
    check_eq("drop2_req", 32'(bus.imem_req), 32'd1);
    rst_n = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    cycle();
    check_reset("midrst");
    rst_n = 1'b1;
    wait_states = 0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    cycle();
    check_eq("refetch_req", 32'(bus.imem_req), 32'd1);
    check_eq("refetch_addr", bus.imem_addr, 32'h0);
    check_eq("refetch_valid", 32'(bus.instr_valid), 32'd0);
    cycle();
    check_eq("refetch_ipc", bus.instr_pc, 32'h0);
    check_eq("refetch_instr", bus.instr, mem_word(32'h0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
